// File: rtl/decode_regfile_pkg.sv
// ---------------------------------------------------------------------------
// decode_regfile_pkg
// Shared defaults and types for the decode-stage register file and its
// scoreboard.
//   DATA_W_DEF   : default register data width
//   NUM_REGS_DEF : default architectural register count (power of two)
//   ADDR_W_DEF   : register address width derived from NUM_REGS_DEF
//   reg_addr_t   : register address at the default sizing
//   reg_data_t   : register data word at the default sizing
//   addr_w()     : address width for a given register count
// ---------------------------------------------------------------------------
package decode_regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned NUM_REGS_DEF = 32;

    function automatic int unsigned addr_w(input int unsigned num_regs);
        return $clog2(num_regs);
    endfunction

    localparam int unsigned ADDR_W_DEF = addr_w(NUM_REGS_DEF);

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/decode_scoreboard.sv
// ---------------------------------------------------------------------------
// decode_scoreboard
// Tracks which registers still await write-back from an issued producer.
//   clk         : clock, updates on rising edge
//   rst_n       : asynchronous active-low reset, clears all pending bits
//   iss_valid_i : an instruction with a destination issues this cycle
//   iss_addr_i  : destination of the issuing instruction
//   wr_en_i     : write-back strobe
//   wr_addr_i   : write-back destination
//   pending_o   : bit n set = register n awaiting write-back
// ---------------------------------------------------------------------------
module decode_scoreboard
    import decode_regfile_pkg::*;
#(
    parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
    localparam int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                iss_valid_i,
    input  logic [ADDR_W-1:0]   iss_addr_i,
    input  logic                wr_en_i,
    input  logic [ADDR_W-1:0]   wr_addr_i,
    output logic [NUM_REGS-1:0] pending_o
);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Clear is applied before set so a same-cycle issue to the register being
    // written back keeps it pending: the issuing instruction is the newer
    // producer.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_i) begin
            pending_d[wr_addr_i] = 1'b0;
        end
        if (iss_valid_i && (iss_addr_i != '0)) begin
            pending_d[iss_addr_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/decode_regfile.sv
// ---------------------------------------------------------------------------
// decode_regfile
// Decode-stage register file: multi-port combinational read, single write-back
// port, register 0 hard-wired to zero, scoreboard-driven hazard stall and a
// port 0 / port 1 equality compare for branches.
//   clk       : clock, state updates on rising edge
//   rst_n     : asynchronous active-low reset
//   rd_addr   : read address per port       (NUM_RD x ADDR_W)
//   rd_en     : read port in use; gates hazard detection only
//   rd_data   : read data per port          (NUM_RD x DATA_W)
//   wr_en     : write-back strobe
//   wr_addr   : write-back destination
//   wr_data   : write-back data
//   iss_valid : instruction with a destination leaves decode
//   iss_addr  : destination of the issuing instruction
//   stall     : an enabled read port targets a pending register
//   equal     : rd_data[0] == rd_data[1]
//   pending   : scoreboard vector
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write-back data
// to matching read ports (and suppress their stall).
// ---------------------------------------------------------------------------
module decode_regfile
    import decode_regfile_pkg::*;
#(
    parameter  int unsigned DATA_W   = DATA_W_DEF,
    parameter  int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter  int unsigned NUM_RD   = 2,
    localparam int unsigned ADDR_W   = addr_w(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr,
    input  logic [NUM_RD-1:0]              rd_en,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
    input  logic                           wr_en,
    input  logic [ADDR_W-1:0]              wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           iss_valid,
    input  logic [ADDR_W-1:0]              iss_addr,
    output logic                           stall,
    output logic                           equal,
    output logic [NUM_REGS-1:0]            pending
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [NUM_RD-1:0] byp_hit;
    logic [NUM_RD-1:0] stall_hit;

    decode_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid_i (iss_valid),
        .iss_addr_i  (iss_addr),
        .wr_en_i     (wr_en),
        .wr_addr_i   (wr_addr),
        .pending_o   (pending)
    );

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en && (wr_addr != '0)) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        byp_hit   = '0;
        stall_hit = '0;
        rd_data   = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
`ifdef REGFILE_BYPASS_EN
            // Gated by rst_n so reads stay zero while reset is held.
            byp_hit[p] = rst_n && wr_en && (wr_addr != '0) && (wr_addr == rd_addr[p]);
`endif
            rd_data[p]   = byp_hit[p] ? wr_data : regs_q[rd_addr[p]];
            stall_hit[p] = rd_en[p] && pending[rd_addr[p]] && !byp_hit[p];
        end
    end

    assign stall = |stall_hit;
    assign equal = (rd_data[0] == rd_data[1]);

endmodule

// File: doc/decode_regfile.md
DECODE_REGFILE -- requirements
Module: decode_regfile

Interface
- REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
- REQ-002 The block SHALL have parameter NUM_REGS, default 32, architectural register count, power of two, minimum 2.
- REQ-003 The block SHALL have parameter NUM_RD, default 2, number of independent read ports, minimum 2.
- REQ-004 Derived constant ADDR_W = log2(NUM_REGS) SHALL size every register address.
- REQ-005 clk  input  1  single clock; all state updates on its rising edge.
- REQ-006 rst_n  input  1  reset, asynchronous and active-low.
- REQ-007 rd_addr  input  NUM_RD x ADDR_W  read address per port.
- REQ-008 rd_en  input  NUM_RD  read port in use; gates hazard detection only.
- REQ-009 rd_data  output  NUM_RD x DATA_W  read data per port.
- REQ-010 wr_en  input  1  write-back strobe.
- REQ-011 wr_addr  input  ADDR_W  write-back destination.
- REQ-012 wr_data  input  DATA_W  write-back data.
- REQ-013 iss_valid  input  1  an instruction with a destination leaves decode this cycle.
- REQ-014 iss_addr  input  ADDR_W  destination of the issuing instruction.
- REQ-015 stall  output  1  some enabled read port targets a pending register.
- REQ-016 equal  output  1  rd_data port 0 equals rd_data port 1 (branch compare).
- REQ-017 pending  output  NUM_REGS  scoreboard bit vector, bit n = register n awaiting write-back.

Function
- REQ-018 Register 0 SHALL always read 0; writes to it SHALL be discarded; its pending bit SHALL never set.
- REQ-019 A write with wr_en=1 SHALL update the addressed register at the rising edge; reads are combinational from the array.
- REQ-020 Reads of the same register on multiple ports in the same cycle SHALL all return identical data.
- REQ-021 iss_valid=1 with iss_addr!=0 SHALL set pending[iss_addr] at the next edge.
- REQ-022 wr_en=1 SHALL clear pending[wr_addr] at the next edge.
- REQ-023 Same register set by issue and cleared by write-back in one cycle: set SHALL win (newer producer).
- REQ-024 stall SHALL be combinational: OR over ports p of rd_en[p] AND pending[rd_addr[p]] AND NOT (wr_en AND wr_addr==rd_addr[p] under REQ-030).
- REQ-025 stall SHALL NOT inhibit writes or scoreboard updates; the upstream stage holds iss_valid low while stalled.
- REQ-026 equal SHALL compare the final (post-bypass) rd_data of ports 0 and 1 over full DATA_W.
- REQ-027 Out-of-range addresses cannot occur (NUM_REGS is a power of two); no wrap handling is required.

Reset
- REQ-028 While rst_n=0 every register SHALL hold 0, pending SHALL be all zeros; hence rd_data=0, equal=1, stall=0.
- REQ-029 Assertion mid-operation SHALL abort any write in that cycle and clear the scoreboard immediately, without waiting for clk.

Configuration
- REQ-030 Macro REGFILE_BYPASS_EN defined: a read of wr_addr (non-zero) while wr_en=1 SHALL return wr_data in the same cycle and that port SHALL not raise stall.
- REQ-031 Macro REGFILE_BYPASS_EN undefined: such a read SHALL return the old array value, and stall SHALL remain asserted until the cycle after the write.

Structure
- REQ-032 A shared package SHALL hold DATA_W/NUM_REGS defaults, the ADDR_W derivation, and typedefs reg_addr_t and reg_data_t.
- REQ-033 The scoreboard SHALL be one sub-module, decode_scoreboard (set/clear logic and pending vector); the array, bypass and compare stay in decode_regfile.

Verification
- REQ-034 Reset, then read all addresses on both ports -> rd_data=0, equal=1, stall=0, pending=0.
- REQ-035 Write 0xDEADBEEF to r5, next cycle read r5 on ports 0 and 1 -> both 0xDEADBEEF, equal=1; write 0x1234 to r0 then read r0 -> 0.
- REQ-036 iss_valid with iss_addr=7, next cycle rd_en[0]=1 rd_addr[0]=7 -> stall=1, pending[7]=1; wr_en r7=0x55 -> bypass build: rd_data=0x55 and stall=0 that cycle; no-bypass build: stall=1 that cycle, 0 next.
- REQ-037 Same cycle iss_valid r3 and wr_en r3=0xA -> pending[3]=1 after the edge, register r3=0xA.
- REQ-038 Set pending r9, assert rst_n=0 between edges -> pending[9]=0 and r9 reads 0 before the next clk.
- REQ-039 NUM_RD=4, DATA_W=16 build: four ports read r1..r4 after writing 0x0001..0x0004 -> each port returns its value; equal=0.
